// File: rtl/gf2_div_pkg.sv
// Shared types and width helpers for the sequential GF(2)[x] polynomial divider.
package gf2_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Defaults match the product width of a 16x16 carry-less multiplier.
    localparam int DW_A_DEF = 31;
    localparam int DW_B_DEF = 16;

    // Normalisation shift count: 0..DW_B-1.
    function automatic int shift_cnt_w(input int dw_b);
        return $clog2(dw_b);
    endfunction

    // Division iteration count: up to DW_A + DW_B - 1.
    function automatic int iter_cnt_w(input int dw_a, input int dw_b);
        return $clog2(dw_a + dw_b);
    endfunction

endpackage

// File: rtl/gf2_lzc.sv
// Parameterised leading-zero counter, purely combinational.
// Returns W when the input is all zeros.
module gf2_lzc #(
    parameter int W  = 31,
    parameter int ZW = $clog2(W + 1)
) (
    input  logic [W-1:0]  x,
    output logic [ZW-1:0] cnt
);

    // Highest set bit wins because later iterations overwrite earlier ones.
    always_comb begin
        cnt = ZW'(W);
        for (int i = 0; i < W; i++) begin
            if (x[i]) cnt = ZW'(W - 1 - i);
        end
    end

endmodule

// File: rtl/gf2_poly_div_seq.sv
// Sequential carry-less polynomial divider: a(x) = q(x)*b(x) ^ r(x), deg r < deg b.
// The divisor is first normalised (shifted until its top bit is set), then one
// quotient bit is produced per clock, MSB first, from the stream a followed by s zeros.
// Optional macro GF2_DIV_EARLY_EXIT_EN skips the leading zeros of the dividend,
// shortening latency without changing q, r or div0.
module gf2_poly_div_seq
    import gf2_div_pkg::*;
#(
    parameter int DW_A = DW_A_DEF,
    parameter int DW_B = DW_B_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW_A-1:0] a,
    input  logic [DW_B-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW_A-1:0] q,
    output logic [DW_B-2:0] r,
    output logic            div0
);

    localparam int SW = shift_cnt_w(DW_B);
    localparam int CW = iter_cnt_w(DW_A, DW_B);

    state_t          state;
    logic [DW_A-1:0] src;       // dividend bits still to be consumed, MSB first
    logic [DW_B-1:0] b_norm;    // divisor shifted so its top bit is set
    logic [DW_B-2:0] rem;       // running partial remainder
    logic [DW_A-1:0] q_reg;
    logic [DW_B-2:0] r_reg;
    logic            div0_reg;
    logic [SW-1:0]   s;         // normalisation shift applied to the divisor
    logic [CW-1:0]   cnt;       // remaining division steps
    logic [CW-1:0]   n_iter;    // steps needed for the current job
    logic [DW_A-1:0] a_src;     // dividend as loaded into the stream register

    logic [DW_B-1:0] t;
    logic [DW_B-1:0] t_x;
    logic [DW_B-2:0] rem_nxt;
    logic            qbit;

`ifdef GF2_DIV_EARLY_EXIT_EN
    localparam int ZW = $clog2(DW_A + 1);
    logic [ZW-1:0] a_lz;
    logic [ZW-1:0] z;

    gf2_lzc #(.W(DW_A), .ZW(ZW)) u_lzc (
        .x   (a),
        .cnt (a_lz)
    );

    // Left-align the dividend so the stream starts at its first set bit.
    assign a_src  = a << a_lz;
    assign n_iter = CW'(DW_A) - CW'(z) + CW'(s);
`else
    assign a_src  = a;
    assign n_iter = CW'(DW_A) + CW'(s);
`endif

    // One long-division step: shift in the next dividend bit, subtract (XOR) if the top bit is set.
    always_comb begin
        t       = {rem, src[DW_A-1]};
        t_x     = t ^ b_norm;
        qbit    = t[DW_B-1];
        rem_nxt = qbit ? t_x[DW_B-2:0] : t[DW_B-2:0];
    end

    // Control FSM and datapath registers: accept, normalise, divide, hold result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            src      <= '0;
            b_norm   <= '0;
            rem      <= '0;
            q_reg    <= '0;
            r_reg    <= '0;
            div0_reg <= 1'b0;
            s        <= '0;
            cnt      <= '0;
`ifdef GF2_DIV_EARLY_EXIT_EN
            z        <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        src      <= a_src;
                        b_norm   <= b;
                        s        <= '0;
                        rem      <= '0;
                        q_reg    <= '0;
                        r_reg    <= '0;
                        div0_reg <= 1'b0;
`ifdef GF2_DIV_EARLY_EXIT_EN
                        z        <= a_lz;
`endif
                        state    <= NORM;
                    end
                end
                NORM: begin
                    if (b_norm == '0) begin
                        div0_reg <= 1'b1;
                        q_reg    <= '0;
                        r_reg    <= '0;
                        state    <= DONE;
                    end else if (b_norm[DW_B-1]) begin
                        // Only reachable with early exit and a zero dividend and s == 0.
                        if (n_iter == '0) begin
                            state <= DONE;
                        end else begin
                            cnt   <= n_iter;
                            state <= DIV;
                        end
                    end else begin
                        b_norm <= b_norm << 1;
                        s      <= s + SW'(1);
                    end
                end
                DIV: begin
                    rem   <= rem_nxt;
                    q_reg <= {q_reg[DW_A-2:0], qbit};
                    src   <= {src[DW_A-2:0], 1'b0};
                    cnt   <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        // Undo the normalisation scaling on the remainder.
                        r_reg <= rem_nxt >> s;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign q         = q_reg;
    assign r         = r_reg;
    assign div0      = div0_reg;

endmodule

// File: tb/tb_gf2_poly_div_seq.sv
// Scoreboard bench for gf2_poly_div_seq: a driver pushes expected results,
// a monitor pops and compares whenever a result is handed over.
module tb_gf2_poly_div_seq;

    localparam int DW_A = 31;
    localparam int DW_B = 16;

    typedef struct {
        logic [DW_A-1:0] q;
        logic [DW_B-2:0] r;
        logic            d0;
        int              lat;
        int              acc;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [DW_A-1:0] a_i;
    logic [DW_B-1:0] b_i;
    logic            out_valid;
    logic            out_ready;
    logic [DW_A-1:0] q;
    logic [DW_B-2:0] r;
    logic            div0;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic hold = 1'b0;

    gf2_poly_div_seq #(.DW_A(DW_A), .DW_B(DW_B)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a_i),
        .b         (b_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q),
        .r         (r),
        .div0      (div0)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Degree of a polynomial, -1 for the zero polynomial.
    function automatic int deg(input logic [DW_A-1:0] v);
        int d = -1;
        for (int i = 0; i < DW_A; i++) if (v[i]) d = i;
        return d;
    endfunction

    // Schoolbook long division over GF(2).
    function automatic void div_model(input logic [DW_A-1:0] a, input logic [DW_B-1:0] b,
                                      output logic [DW_A-1:0] qo, output logic [DW_B-2:0] ro);
        logic [DW_A-1:0] rem = a;
        logic [DW_A-1:0] bw  = DW_A'(b);
        int db = deg(bw);
        qo = '0;
        for (int i = DW_A - 1; i >= db; i--) begin
            if (rem[i]) begin
                rem ^= bw << (i - db);
                qo[i - db] = 1'b1;
            end
        end
        ro = rem[DW_B-2:0];
    endfunction

    // Carry-less 16x16 product.
    function automatic logic [DW_A-1:0] clmul(input logic [15:0] x, input logic [15:0] y);
        logic [DW_A-1:0] p = '0;
        for (int i = 0; i < 16; i++) if (y[i]) p ^= DW_A'(x) << i;
        return p;
    endfunction

    function automatic int exp_lat(input logic [DW_A-1:0] a, input logic [DW_B-1:0] b);
        int s, z;
        if (b == '0) return 1;
        s = (DW_B - 1) - deg(DW_A'(b));
`ifdef GF2_DIV_EARLY_EXIT_EN
        z = (DW_A - 1) - deg(a);
`else
        z = 0;
`endif
        return 2 * s + 1 + DW_A - z;
    endfunction

    task automatic send(input logic [DW_A-1:0] a, input logic [DW_B-1:0] b,
                        input logic [DW_A-1:0] eq, input logic [DW_B-2:0] er,
                        input logic ed0, input bit push);
        exp_t e;
        int w = 0;
        @(negedge clk);
        while (!in_ready && w < 400) begin
            @(negedge clk);
            w++;
        end
        if (w >= 400) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: got 0, expected 1 within 400 cycles");
        end
        a_i = a;
        b_i = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (push) begin
            e.q = eq; e.r = er; e.d0 = ed0;
            e.lat = exp_lat(a, b);
            e.acc = cyc;
            sb.push_back(e);
        end
    endtask

    task automatic send_model(input logic [DW_A-1:0] a, input logic [DW_B-1:0] b);
        logic [DW_A-1:0] mq;
        logic [DW_B-2:0] mr;
        if (b == '0) send(a, b, '0, '0, 1'b1, 1'b1);
        else begin
            div_model(a, b, mq, mr);
            send(a, b, mq, mr, 1'b0, 1'b1);
        end
    endtask

    task automatic wait_drain();
        int w = 0;
        while (sb.size() != 0 && w < 1000) begin
            @(negedge clk);
            w++;
        end
        if (w >= 1000) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", sb.size());
        end
    endtask

    // Monitor: drives out_ready and checks each handed-over result.
    initial begin
        exp_t e;
        logic prev_v = 1'b0;
        int   rise = 0;
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            out_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
            if (out_valid && !prev_v) rise = cyc;
            prev_v = out_valid;
            if (rst_n && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got q=0x%0h r=0x%0h, expected none", q, r);
                end else begin
                    e = sb.pop_front();
                    chk("q", 64'(q), 64'(e.q));
                    chk("r", 64'(r), 64'(e.r));
                    chk("div0", 64'(div0), 64'(e.d0));
                    chk("latency", 64'(rise - e.acc), 64'(e.lat));
                end
            end
        end
    end

    initial begin
        logic [15:0] x, y;
        logic [DW_A-1:0] ra;
        logic [DW_B-1:0] rb;
        int w;

        rst_n = 1'b0; in_valid = 1'b0; a_i = '0; b_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_q", 64'(q), 64'd0);
        chk("rst_r", 64'(r), 64'd0);
        chk("rst_div0", 64'(div0), 64'd0);
        rst_n = 1'b1;

        // Directed cases with hand-derived results.
        send(31'h11, 16'h5, 31'h5, 15'h0, 1'b0, 1'b1);
        send(31'h7FFFFFFF, 16'h8000, 31'hFFFF, 15'h7FFF, 1'b0, 1'b1);
        send(31'h7FFFFFFF, 16'h1, 31'h7FFFFFFF, 15'h0, 1'b0, 1'b1);
        send(31'h1234567, 16'h0, 31'h0, 15'h0, 1'b1, 1'b1);
        send(31'h40000001, 16'h3, 31'h3FFFFFFF, 15'h0, 1'b0, 1'b1);
`ifdef GF2_DIV_EARLY_EXIT_EN
        send(31'h0, 16'h8000, 31'h0, 15'h0, 1'b0, 1'b1);
`endif
        wait_drain();

        // Result held in DONE while the consumer stalls; extra inputs ignored.
        hold = 1'b1;
        send(31'h11, 16'h5, 31'h5, 15'h0, 1'b0, 1'b1);
        w = 0;
        while (!out_valid && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("hold_reached_done", 64'(out_valid), 64'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("hold_out_valid", 64'(out_valid), 64'd1);
            chk("hold_in_ready", 64'(in_ready), 64'd0);
            chk("hold_q", 64'(q), 64'h5);
            chk("hold_r", 64'(r), 64'h0);
            a_i = 31'($urandom);
            b_i = 16'($urandom);
            in_valid = (k % 2 == 0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        hold = 1'b0;
        wait_drain();

        // Reset in the middle of a division abandons the job.
        send(31'h7FFFFFFF, 16'h8000, '0, '0, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_q", 64'(q), 64'd0);
        chk("midrst_r", 64'(r), 64'd0);
        send(31'h7FFFFFFF, 16'h8000, 31'hFFFF, 15'h7FFF, 1'b0, 1'b1);
        wait_drain();

        // Random dividends and divisors of assorted degrees against the model.
        for (int i = 0; i < 100; i++) begin
            ra = 31'($urandom);
            if ($urandom_range(0, 9) == 0) rb = '0;
            else rb = 16'($urandom) >> $urandom_range(0, 15);
            send_model(ra, rb);
        end

        // Round trip through a carry-less product.
        for (int i = 0; i < 1000; i++) begin
            x = 16'($urandom);
            y = 16'($urandom_range(1, 65535));
            send(clmul(x, y), y, DW_A'(x), '0, 1'b0, 1'b1);
        end
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
